// File: rtl/init_pop_if.sv
// Start/seed request and population/done result bundle for init_pop.
// Signals:
//   start      - level request to generate a population (master -> slave)
//   prg_seed   - 32-bit PRNG seed, sampled on the accepting edge (master -> slave)
//   population - POP_W-bit generated population (slave -> master)
//   done       - population complete and valid (slave -> master)
//   busy       - generation in progress, only when INITPOP_BUSY_EN is defined
interface init_pop_if #(
  parameter int unsigned POP_W = 7501
);
  logic              start;
  logic [31:0]       prg_seed;
  logic [POP_W-1:0]  population;
  logic              done;
`ifdef INITPOP_BUSY_EN
  logic              busy;
`endif

`ifdef INITPOP_BUSY_EN
  modport master (output start, output prg_seed, input population, input done, input busy);
  modport slave  (input start, input prg_seed, output population, output done, output busy);
`else
  modport master (output start, output prg_seed, input population, input done);
  modport slave  (input start, input prg_seed, output population, output done);
`endif
endinterface

// File: rtl/init_pop.sv
// Initial population generator for the genetic-algorithm engine.
// On an accepted start the xorshift32 PRNG is seeded from prg_seed and the
// population vector is filled one 32-bit word per clock, after which done
// is raised and held until start drops.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - init_pop_if.slave: start, prg_seed in; population, done (busy) out
// Optional feature macro: INITPOP_BUSY_EN adds a registered busy output that
// is high exactly while the generator is in the GEN state.
module init_pop #(
  parameter int unsigned POP_W     = 7501,
  parameter logic [31:0] ZERO_SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  init_pop_if.slave   bus
);

  localparam int unsigned NUM_WORDS = (POP_W + 31) / 32;
  localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      prng_q, prng_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [POP_W-1:0] pop_q, pop_d;
  logic             done_q, done_d;
  logic [31:0]      nxt;
`ifdef INITPOP_BUSY_EN
  logic             busy_q, busy_d;
`endif

  // xorshift32 step, all shifts truncated to 32 bits
  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  assign nxt = xs_step(prng_q);

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      prng_q  <= '0;
      idx_q   <= '0;
      pop_q   <= '0;
      done_q  <= 1'b0;
`ifdef INITPOP_BUSY_EN
      busy_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prng_q  <= prng_d;
      idx_q   <= idx_d;
      pop_q   <= pop_d;
      done_q  <= done_d;
`ifdef INITPOP_BUSY_EN
      busy_q  <= busy_d;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    prng_d  = prng_q;
    idx_d   = idx_q;
    pop_d   = pop_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (bus.start) begin
          // xorshift has a fixed point at zero, so a zero seed is replaced
          prng_d  = (bus.prg_seed == 32'd0) ? ZERO_SEED : bus.prg_seed;
          pop_d   = '0;
          idx_d   = '0;
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        prng_d = nxt;
        // Bit-wise write keeps the truncated last word inside POP_W
        for (int unsigned b = 0; b < POP_W; b++) begin
          if (IDX_W'(b >> 5) == idx_q) pop_d[b] = nxt[b[4:0]];
        end
        idx_d = IDX_W'(idx_q + 1'b1);
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        // Requires start low for an edge before a new run can be accepted
        if (!bus.start) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

`ifdef INITPOP_BUSY_EN
  assign busy_d = (state_d == S_GEN);
  assign bus.busy = busy_q;
`endif

  assign bus.population = pop_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_init_pop.sv
module tb_init_pop;

  localparam int unsigned POP_W     = 7501;
  localparam int unsigned NUM_WORDS = 235;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  init_pop_if #(.POP_W(POP_W)) bus ();

  init_pop #(.POP_W(POP_W), .ZERO_SEED(32'h0000_0001)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [POP_W-1:0] ref_pop(input logic [31:0] seed);
    logic [31:0]      x;
    logic [POP_W-1:0] p;
    x = (seed == 32'd0) ? 32'h1 : seed;
    p = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      x = ref_step(x);
      for (int j = 0; j < 32; j++)
        if (k * 32 + j < POP_W) p[k * 32 + j] = x[j];
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_last(input logic [31:0] seed);
    logic [31:0] x;
    x = (seed == 32'd0) ? 32'h1 : seed;
    for (int k = 0; k < NUM_WORDS; k++) x = ref_step(x);
    return x;
  endfunction

  // Accept start with the given seed, then wait for done and check latency
  task automatic run_gen(input logic [31:0] seed, input string tag);
    int n;
    int busy_n;
    @(negedge clk);
    bus.prg_seed = seed;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_pop_clr"}, 64'(bus.population == '0), 64'd1);
    check({tag, "_done_lo"}, 64'(bus.done), 64'd0);
    busy_n = 0;
`ifdef INITPOP_BUSY_EN
    if (bus.busy) busy_n++;
`endif
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
`ifdef INITPOP_BUSY_EN
      if (bus.busy) busy_n++;
`endif
    end while (!bus.done && n < 400);
    check({tag, "_latency"}, 64'(n), 64'(NUM_WORDS));
`ifdef INITPOP_BUSY_EN
    check({tag, "_busy_cyc"}, 64'(busy_n), 64'(NUM_WORDS));
    check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
`endif
  endtask

  // Drop start for one edge; done must fall on that edge
  task automatic drop_start(input string tag);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_done_fall"}, 64'(bus.done), 64'd0);
  endtask

  logic [POP_W-1:0] snap;
  logic [POP_W-1:0] exp1;
  logic [31:0]      last;
  logic             stable_bad;
  logic             done_bad;

  initial begin
    n_vec        = 0;
    n_bad        = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.prg_seed = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pop", 64'(bus.population == '0), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
`ifdef INITPOP_BUSY_EN
    check("rst_busy", 64'(bus.busy), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Seed 1: hand-computed first two words
    run_gen(32'd1, "s1");
    check("s1_w0", 64'(bus.population[31:0]), 64'h0004_2021);
    check("s1_w1", 64'(bus.population[63:32]), 64'h0408_0601);
    exp1 = ref_pop(32'd1);
    check("s1_full", 64'(bus.population == exp1), 64'd1);
    last = ref_last(32'd1);
    check("s1_top", 64'(bus.population[7500:7488]), 64'(last[12:0]));

    // Zero seed must behave as seed 1
    drop_start("z");
    run_gen(32'd0, "z");
    check("z_full", 64'(bus.population == exp1), 64'd1);

    // Large seed held high for a long time: no retrigger, stable output
    drop_start("h");
    run_gen(32'd2682981917, "h");
    snap = bus.population;
    check("h_full", 64'(snap == ref_pop(32'd2682981917)), 64'd1);
    check("h_nonzero", 64'(snap != '0), 64'd1);
    last = ref_last(32'd2682981917);
    check("h_top", 64'(bus.population[7500:7488]), 64'(last[12:0]));
    stable_bad = 1'b0;
    done_bad   = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (bus.population !== snap) stable_bad = 1'b1;
      if (bus.done !== 1'b1) done_bad = 1'b1;
    end
    check("h_pop_stable", 64'(stable_bad), 64'd0);
    check("h_done_held", 64'(done_bad), 64'd0);

    // Restart with the same seed gives a bit-identical population
    drop_start("r");
    run_gen(32'd2682981917, "r");
    check("r_same", 64'(bus.population == snap), 64'd1);

    // Asynchronous reset around word 100 of a run
    drop_start("m");
    @(negedge clk);
    bus.prg_seed = 32'hDEAD_BEEF;
    bus.start    = 1'b1;
    @(posedge clk);
    repeat (100) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("m_pop", 64'(bus.population == '0), 64'd1);
    check("m_done", 64'(bus.done), 64'd0);
`ifdef INITPOP_BUSY_EN
    check("m_busy", 64'(bus.busy), 64'd0);
`endif
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_gen(32'd5, "p");
    check("p_full", 64'(bus.population == ref_pop(32'd5)), 64'd1);
    last = ref_last(32'd5);
    check("p_top", 64'(bus.population[7500:7488]), 64'(last[12:0]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
